rand_unit_vec_gen: RTL and testbench
====================================

RAND_UNIT_VEC_GEN -- requirements
Module: rand_unit_vec_gen

Interface
REQ-001 SHALL have parameter MIN_SQ, default 34'h0_0001_0000, giving the minimum accepted squared length in Q4.30; shorter vectors are rejected as degenerate.
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port gen_en, input, 1 bit: permits the start of a new sample attempt.
REQ-005 SHALL have port rand_num, input, 16 bits: current upstream xorshift PRNG word, read as signed Q1.15.
REQ-006 SHALL have port prng_en, output, 1 bit: advance strobe to the PRNG; one word is consumed per high cycle.
REQ-007 SHALL have port vec_valid, output, 1 bit: accepted vector available.
REQ-008 SHALL have port vec_ready, input, 1 bit: downstream accepts the vector.
REQ-009 SHALL have ports vec_x, vec_y and vec_z, outputs, 16 bits each: signed Q1.15 components of a point inside the unit sphere.
REQ-010 SHALL have port reject_cnt, output, 16 bits: saturating count of rejected attempts since reset.

Function
REQ-011 SHALL implement an FSM with the states FETCH_X, FETCH_Y, FETCH_Z, CHECK and HOLD.
REQ-012 FETCH_X with gen_en=1 SHALL register rand_num into x, assert prng_en and go to FETCH_Y; FETCH_X with gen_en=0 SHALL stay in FETCH_X with prng_en=0.
REQ-013 FETCH_Y and FETCH_Z SHALL each register rand_num into y or z, assert prng_en and advance one state per cycle, regardless of gen_en.
REQ-014 prng_en SHALL be high only in the three capture cycles, so x, y and z are three consecutive PRNG words.
REQ-015 CHECK SHALL compute sum = x*x + y*y + z*z as a 34-bit unsigned Q4.30 value with no truncation; each product is 32-bit signed.
REQ-016 CHECK SHALL accept when MIN_SQ <= sum < 34'h0_4000_0000 (1.0 is strict, so -1.0 on one axis is rejected), and SHALL then go to HOLD.
REQ-017 On reject, CHECK SHALL go to FETCH_X and increment reject_cnt, which holds at 16'hFFFF.
REQ-018 vec_valid SHALL be high exactly in HOLD, and vec_x, vec_y and vec_z SHALL equal the registered x, y and z.
REQ-019 Outputs SHALL stay stable while vec_valid=1 and vec_ready=0.
REQ-020 HOLD with vec_ready=1 SHALL complete the transfer that cycle and go to FETCH_X.
REQ-021 vec_valid SHALL NOT depend combinationally on vec_ready.
REQ-022 Minimum latency SHALL be: FETCH_X with gen_en=1 at cycle n gives vec_valid=1 at cycle n+4, on first-try accept.
REQ-023 Sustained throughput SHALL be at most one vector per 5 cycles; there is no overlap of fetch with HOLD.
REQ-024 gen_en SHALL be ignored outside FETCH_X, so an attempt once started always completes.

Reset
REQ-025 While rst=1 at a clock edge, the FSM SHALL go to FETCH_X and clear x, y, z and reject_cnt to 0.
REQ-026 After reset, prng_en and vec_valid SHALL be 0, and vec_x, vec_y and vec_z SHALL be 16'h0000.
REQ-027 Reset in any state, including mid-fetch or HOLD, SHALL abandon the attempt; partial captures SHALL NOT be reused.

Structure
REQ-028 A shared package rt_rand_pkg SHALL hold the FSM state enum typedef, FRAC_BITS=15, ONE_SQ=34'h0_4000_0000 and the default MIN_SQ.
REQ-029 The squared-length datapath SHALL be one combinational sub-module, vec_sumsq (3x16-bit signed in, 34-bit unsigned out).
REQ-030 Instantiation of the PRNG SHALL be outside this block; this block only drives its enable.

Verification
REQ-031 Stub rand_num 16'h4000, 16'h4000, 16'h4000 with gen_en=1 -> sum 0.75 accepted; vec_valid=1 four cycles after FETCH_X with all components 16'h4000; reject_cnt=0.
REQ-032 Stub 16'h7000 three times, then 16'h2000 three times -> first attempt rejected (sum about 2.30); reject_cnt=1; six prng_en pulses in total; the output vector is 16'h2000 on all axes.
REQ-033 Boundaries -> 16'h8000, 0, 0 (sum exactly 1.0) is rejected; 0, 0, 0 (sum below MIN_SQ) is rejected; 16'h7FFF, 0, 0 is accepted.
REQ-034 Hold vec_ready=0 for 10 cycles in HOLD -> vec_valid and all vec_* stay constant and prng_en=0; with vec_ready=1, FETCH_X follows on the next cycle.
REQ-035 Assert rst for one cycle in FETCH_Z -> next cycle in FETCH_X, reject_cnt=0, vec_valid=0; the next vector uses three fresh words.
REQ-036 Force 70000 consecutive rejects -> reject_cnt saturates at 16'hFFFF and does not wrap.

Source files
------------

// File: rtl/rt_rand_pkg.sv
// rtl/rt_rand_pkg.sv - shared types and constants for the unit-sphere vector sampler
package rt_rand_pkg;

  typedef enum logic [2:0] {
    FETCH_X = 3'd0,
    FETCH_Y = 3'd1,
    FETCH_Z = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam int          FRAC_BITS  = 15;
  localparam logic [33:0] ONE_SQ     = 34'h0_4000_0000;
  localparam logic [33:0] DEF_MIN_SQ = 34'h0_0001_0000;

  // Upper bound is strict so a lone -1.0 component (sum exactly 1.0) is rejected.
  function automatic logic sq_in_range(input logic [33:0] sum_sq,
                                       input logic [33:0] min_sq);
    return (sum_sq >= min_sq) && (sum_sq < ONE_SQ);
  endfunction

endpackage

// File: rtl/vec_sumsq.sv
// rtl/vec_sumsq.sv - squared length of a Q1.15 3-vector as unsigned Q4.30
module vec_sumsq (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  output logic [33:0] sum_sq
);

  logic signed [31:0] px;
  logic signed [31:0] py;
  logic signed [31:0] pz;

  // Squares are non-negative and at most 2^30, so the 32-bit signed products never overflow.
  assign px = $signed({{16{x[15]}}, x}) * $signed({{16{x[15]}}, x});
  assign py = $signed({{16{y[15]}}, y}) * $signed({{16{y[15]}}, y});
  assign pz = $signed({{16{z[15]}}, z}) * $signed({{16{z[15]}}, z});

  assign sum_sq = {2'b00, px} + {2'b00, py} + {2'b00, pz};

endmodule

// File: rtl/rand_unit_vec_gen.sv
// rtl/rand_unit_vec_gen.sv - rejection sampler producing random points inside the unit sphere
module rand_unit_vec_gen
  import rt_rand_pkg::*;
#(
  parameter logic [33:0] MIN_SQ = DEF_MIN_SQ
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gen_en,
  input  logic [15:0] rand_num,
  output logic        prng_en,
  output logic        vec_valid,
  input  logic        vec_ready,
  output logic [15:0] vec_x,
  output logic [15:0] vec_y,
  output logic [15:0] vec_z,
  output logic [15:0] reject_cnt
);

  state_t      state;
  logic [15:0] x_q;
  logic [15:0] y_q;
  logic [15:0] z_q;
  logic [15:0] reject_cnt_q;
  logic        vec_valid_q;
  logic [33:0] sum_sq;
  logic        accept;

  vec_sumsq u_sumsq (
    .x      (x_q),
    .y      (y_q),
    .z      (z_q),
    .sum_sq (sum_sq)
  );

  assign accept = sq_in_range(sum_sq, MIN_SQ);

  // The PRNG word is consumed in the same cycle it is captured; no advance while in reset.
  assign prng_en = !rst && (((state == FETCH_X) && gen_en) ||
                            (state == FETCH_Y) || (state == FETCH_Z));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FETCH_X;
      x_q          <= 16'h0000;
      y_q          <= 16'h0000;
      z_q          <= 16'h0000;
      reject_cnt_q <= 16'h0000;
      vec_valid_q  <= 1'b0;
    end else begin
      case (state)
        FETCH_X: begin
          if (gen_en) begin
            x_q   <= rand_num;
            state <= FETCH_Y;
          end
        end
        FETCH_Y: begin
          y_q   <= rand_num;
          state <= FETCH_Z;
        end
        FETCH_Z: begin
          z_q   <= rand_num;
          state <= CHECK;
        end
        CHECK: begin
          if (accept) begin
            vec_valid_q <= 1'b1;
            state       <= HOLD;
          end else begin
            if (reject_cnt_q != 16'hFFFF) begin
              reject_cnt_q <= reject_cnt_q + 16'd1;
            end
            state <= FETCH_X;
          end
        end
        HOLD: begin
          if (vec_ready) begin
            vec_valid_q <= 1'b0;
            state       <= FETCH_X;
          end
        end
        default: begin
          vec_valid_q <= 1'b0;
          state       <= FETCH_X;
        end
      endcase
    end
  end

  assign vec_valid  = vec_valid_q;
  assign vec_x      = x_q;
  assign vec_y      = y_q;
  assign vec_z      = z_q;
  assign reject_cnt = reject_cnt_q;

endmodule

// File: tb/tb_rand_unit_vec_gen.sv
// tb/tb_rand_unit_vec_gen.sv - directed self-checking bench for rand_unit_vec_gen
module tb_rand_unit_vec_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        gen_en;
  logic [15:0] rand_num;
  logic        prng_en;
  logic        vec_valid;
  logic        vec_ready;
  logic [15:0] vec_x;
  logic [15:0] vec_y;
  logic [15:0] vec_z;
  logic [15:0] reject_cnt;

  int tests = 0;
  int fails = 0;

  logic [15:0] words [0:15];
  int          rd_ptr = 0;
  int          pulses = 0;
  int          p0;
  int          lat;

  always #5 clk = ~clk;

  rand_unit_vec_gen dut (
    .clk        (clk),
    .rst        (rst),
    .gen_en     (gen_en),
    .rand_num   (rand_num),
    .prng_en    (prng_en),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_x      (vec_x),
    .vec_y      (vec_y),
    .vec_z      (vec_z),
    .reject_cnt (reject_cnt)
  );

  // Stub PRNG: presents words[rd_ptr] and advances one entry per enabled cycle.
  assign rand_num = words[rd_ptr[3:0]];

  always @(posedge clk) begin
    if (prng_en) begin
      rd_ptr <= rd_ptr + 1;
      pulses <= pulses + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    logic [3:0] p;
    p = rd_ptr[3:0];
    words[p]        = a;
    words[p + 4'd1] = b;
    words[p + 4'd2] = c;
  endtask

  task automatic push6(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] d, input logic [15:0] e, input logic [15:0] f);
    logic [3:0] p;
    p = rd_ptr[3:0];
    words[p]        = a;
    words[p + 4'd1] = b;
    words[p + 4'd2] = c;
    words[p + 4'd3] = d;
    words[p + 4'd4] = e;
    words[p + 4'd5] = f;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (vec_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic release_vec();
    vec_ready = 1'b1;
    gen_en    = 1'b0;
    tick();
    vec_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) words[i] = 16'h0000;
    rst       = 1'b1;
    gen_en    = 1'b0;
    vec_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    chk("reset_prng_en", prng_en, 1'b0);
    chk("reset_vec_valid", vec_valid, 1'b0);
    chk("reset_vec", {vec_x, vec_y, vec_z}, 48'h0);
    chk("reset_reject_cnt", reject_cnt, 16'h0000);

    // 0.5 on each axis: sum 0.75, accepted first time.
    push3(16'h4000, 16'h4000, 16'h4000);
    gen_en = 1'b1;
    #1;
    chk("fetch_x_prng_en", prng_en, 1'b1);
    p0 = pulses;
    tick();
    gen_en = 1'b0;
    tick();
    tick();
    chk("check_state_no_valid", {vec_valid, prng_en}, 2'b00);
    tick();
    chk("latency4_valid", vec_valid, 1'b1);
    chk("accept_vec", {vec_x, vec_y, vec_z}, 48'h4000_4000_4000);
    chk("accept_reject_cnt", reject_cnt, 16'h0000);
    chk("accept_pulses", pulses - p0, 3);

    gen_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_stable", {vec_valid, prng_en, vec_x, vec_y, vec_z},
          {1'b1, 1'b0, 48'h4000_4000_4000});
    end
    release_vec();
    chk("release_to_fetch_x", {vec_valid, prng_en}, 2'b00);

    // Outside-sphere attempt rejected, then 0.25 on each axis accepted.
    push6(16'h7000, 16'h7000, 16'h7000, 16'h2000, 16'h2000, 16'h2000);
    p0 = pulses;
    gen_en = 1'b1;
    wait_valid(lat);
    chk("retry_latency", lat, 8);
    chk("retry_reject_cnt", reject_cnt, 16'h0001);
    chk("retry_pulses", pulses - p0, 6);
    chk("retry_vec", {vec_x, vec_y, vec_z}, 48'h2000_2000_2000);
    release_vec();

    // Sum exactly 1.0 rejected; just below 1.0 accepted.
    push6(16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000);
    gen_en = 1'b1;
    wait_valid(lat);
    chk("one_sq_latency", lat, 8);
    chk("one_sq_reject_cnt", reject_cnt, 16'h0002);
    chk("near_one_vec", {vec_x, vec_y, vec_z}, 48'h7FFF_0000_0000);
    release_vec();

    // Zero vector rejected; squared length exactly MIN_SQ accepted.
    push6(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
    gen_en = 1'b1;
    wait_valid(lat);
    chk("zero_latency", lat, 8);
    chk("zero_reject_cnt", reject_cnt, 16'h0003);
    chk("min_sq_vec", {vec_x, vec_y, vec_z}, 48'h0000_0000_0100);
    release_vec();

    // Squared length just below MIN_SQ rejected.
    push6(16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0100);
    gen_en = 1'b1;
    wait_valid(lat);
    chk("below_min_reject_cnt", {lat[7:0], reject_cnt}, {8'd8, 16'h0004});
    release_vec();

    // Reset while in FETCH_Z abandons the partial capture.
    push3(16'h1111, 16'h2222, 16'h3333);
    gen_en = 1'b1;
    tick();
    tick();
    rst    = 1'b1;
    gen_en = 1'b0;
    #1;
    chk("rst_gates_prng_en", prng_en, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mid_fetch_state", {vec_valid, prng_en}, 2'b00);
    chk("rst_mid_fetch_cnt", reject_cnt, 16'h0000);
    chk("rst_mid_fetch_vec", {vec_x, vec_y, vec_z}, 48'h0);
    push3(16'h0555, 16'h0666, 16'h0777);
    p0 = pulses;
    gen_en = 1'b1;
    wait_valid(lat);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_pulses", pulses - p0, 3);
    chk("post_rst_vec", {vec_x, vec_y, vec_z}, 48'h0555_0666_0777);
    release_vec();

    // Endless zero words: every attempt rejected, four cycles each.
    for (int i = 0; i < 16; i++) words[i] = 16'h0000;
    gen_en = 1'b1;
    repeat (4 * 65534) @(posedge clk);
    #1;
    chk("sat_fffe", reject_cnt, 16'hFFFE);
    repeat (4) @(posedge clk);
    #1;
    chk("sat_ffff", reject_cnt, 16'hFFFF);
    repeat (4 * 8) @(posedge clk);
    #1;
    chk("sat_no_wrap", {vec_valid, reject_cnt}, {1'b0, 16'hFFFF});
    gen_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
